sobel_gradient_core: RTL
========================

SOBEL_GRADIENT_CORE -- requirements
Module: sobel_gradient_core

Interface
REQ-001 Parameter IMG_WIDTH, 320, windows per image row (>=3).
REQ-002 Parameter IMG_HEIGHT, 240, window rows per frame (>=3).
REQ-003 Parameter THRESHOLD, 100, binarisation level on the 11-bit magnitude (used only with SOBEL_THRESHOLD_EN).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 d0_i..d8_i  input  8 each  3x3 grayscale window, row-major: d0 d1 d2 top, d3 d4 d5 middle, d6 d7 d8 bottom.
REQ-007 done_i  input  1  window-valid strobe; one window accepted per cycle high.
REQ-008 edge_o  output  8  edge magnitude (or binary edge) for the window's centre pixel.
REQ-009 done_o  output  1  edge_o valid strobe, one cycle per accepted window.
REQ-010 frame_done_o  output  1  one-cycle pulse coincident with done_o of the last window of a frame.

Function
REQ-011 Gx SHALL be (d2+2*d5+d8)-(d0+2*d3+d6); Gy SHALL be (d6+2*d7+d8)-(d0+2*d1+d2); each 11-bit signed, range -1020..+1020, no overflow.
REQ-012 Stage 1 SHALL register the four 10-bit unsigned partial sums (Gx+, Gx-, Gy+, Gy-) when done_i=1.
REQ-013 Stage 2 SHALL register |Gx| and |Gy| as 10-bit unsigned absolute differences.
REQ-014 Stage 3 SHALL register mag=|Gx|+|Gy| (11-bit, 0..2040) reduced to 8 bits per REQ-024/025, plus border masking.
REQ-015 Latency SHALL be exactly 3 cycles: done_i high at cycle N gives done_o high at N+3 with that window's result.
REQ-016 Each stage's valid bit SHALL follow done_i through the pipe; gaps in done_i SHALL appear as identical gaps on done_o; back-to-back windows every cycle SHALL be sustained.
REQ-017 Pipeline data registers SHALL hold their value when their valid bit is low; edge_o is defined only while done_o=1.
REQ-018 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL tag each accepted window, advancing only on done_i=1.
REQ-019 col SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1 with col wrap (new frame).
REQ-020 Windows with col==0, col==IMG_WIDTH-1, row==0 or row==IMG_HEIGHT-1 SHALL produce edge_o=0 regardless of data.
REQ-021 frame_done_o SHALL assert with done_o for the window tagged col=IMG_WIDTH-1, row=IMG_HEIGHT-1, and at no other time.
REQ-022 The border tag and last-window tag SHALL travel with the window through all 3 stages.
REQ-023 done_i asserted on the cycle after the last window SHALL be tagged col=0,row=0 of the next frame with no dead cycle.

Configuration
REQ-024 Macro SOBEL_THRESHOLD_EN defined: edge_o SHALL be 8'd255 when mag>=THRESHOLD, else 8'd0 (border masking still applied).
REQ-025 Macro SOBEL_THRESHOLD_EN undefined: edge_o SHALL be mag saturated to 255 (mag>255 gives 255); THRESHOLD unused.

Reset
REQ-026 While rst=1 at a clock edge: edge_o=0, done_o=0, frame_done_o=0, all stage valid bits=0, col=0, row=0.
REQ-027 Reset mid-frame SHALL discard in-flight windows (no done_o for them) and tag the next accepted window col=0,row=0.
REQ-028 done_i high during the rst cycle SHALL be ignored.

Verification
REQ-029 Interior window (col=5,row=5) all pixels 50 -> edge_o=0 at done_o, 3 cycles later.
REQ-030 Interior window d0,d3,d6=0, d1,d7=128, d4=128, d2,d5,d8=255 -> Gx=1020, Gy=0; edge_o=255 in both builds.
REQ-031 Interior window d2,d5,d8=10, rest 0 -> mag=40; edge_o=40 without macro, 0 with SOBEL_THRESHOLD_EN and THRESHOLD=100.
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=3, 12 windows all using REQ-030 data, done_i toggled 1/0 -> only (col1..2,row1) give 255, others 0; frame_done_o once, with the 12th done_o; done_o gaps mirror done_i.
REQ-033 Continuous 14 windows (frame 2 starts at window 13) -> window 13 tagged col0,row0 (edge_o=0), frame_done_o exactly once at window 12.
REQ-034 rst pulsed after 7 windows with 2 in flight -> no done_o for in-flight windows; next window tagged col0,row0, outputs 0 during reset.

Source files
------------

// File: rtl/sobel_gradient_core.sv
// sobel_gradient_core: 3-stage Sobel gradient magnitude pipeline over a
// streamed 3x3 window. Each window is tagged with its column and row so that
// border windows give zero, and the last window of a frame raises frame_done_o.
// Optional build macro SOBEL_THRESHOLD_EN: binarise the magnitude against
// THRESHOLD. By default the magnitude is saturated to 8 bits.
module sobel_gradient_core #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int THRESHOLD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d0_i,
    input  logic [7:0] d1_i,
    input  logic [7:0] d2_i,
    input  logic [7:0] d3_i,
    input  logic [7:0] d4_i,
    input  logic [7:0] d5_i,
    input  logic [7:0] d6_i,
    input  logic [7:0] d7_i,
    input  logic [7:0] d8_i,
    input  logic       done_i,
    output logic [7:0] edge_o,
    output logic       done_o,
    output logic       frame_done_o
);

    localparam int STAGES = 3;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // The centre pixel has zero weight in both Sobel kernels.
    logic unused_centre;
    assign unused_centre = ^d4_i;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          border_in;
    logic          last_in;

    logic [STAGES:1] vld_pipe;

    // stage 1: partial sums plus window tags
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [9:0] gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c;
    logic       border1, last1;

    // stage 2: absolute gradients
    logic [9:0] abs_x, abs_y;
    logic       border2, last2;

    // stage 3: magnitude reduction
    logic [10:0] mag;
    logic [7:0]  edge_c;
    logic        last3;

    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign border_in = (col == '0) || col_last || (row == '0) || row_last;
    assign last_in   = col_last && row_last;

    // Position counters advance once per accepted window and wrap per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (done_i) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Kernel partial sums; each is at most 4*255 = 1020, fits in 10 bits.
    always_comb begin
        gx_pos_c = {2'b00, d2_i} + {1'b0, d5_i, 1'b0} + {2'b00, d8_i};
        gx_neg_c = {2'b00, d0_i} + {1'b0, d3_i, 1'b0} + {2'b00, d6_i};
        gy_pos_c = {2'b00, d6_i} + {1'b0, d7_i, 1'b0} + {2'b00, d8_i};
        gy_neg_c = {2'b00, d0_i} + {1'b0, d1_i, 1'b0} + {2'b00, d2_i};
    end

    // Valid shift register: gaps on done_i reappear unchanged on done_o.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], done_i};
    end

    // Stage 1 register: loads only on an accepted window.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_pos  <= '0;
            gx_neg  <= '0;
            gy_pos  <= '0;
            gy_neg  <= '0;
            border1 <= 1'b0;
            last1   <= 1'b0;
        end else if (done_i) begin
            gx_pos  <= gx_pos_c;
            gx_neg  <= gx_neg_c;
            gy_pos  <= gy_pos_c;
            gy_neg  <= gy_neg_c;
            border1 <= border_in;
            last1   <= last_in;
        end
    end

    // Stage 2 register: unsigned absolute differences avoid a signed path.
    always_ff @(posedge clk) begin
        if (rst) begin
            abs_x   <= '0;
            abs_y   <= '0;
            border2 <= 1'b0;
            last2   <= 1'b0;
        end else if (vld_pipe[1]) begin
            abs_x   <= (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
            abs_y   <= (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
            border2 <= border1;
            last2   <= last1;
        end
    end

    assign mag = {1'b0, abs_x} + {1'b0, abs_y};

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [10:0] THR = 11'(THRESHOLD);
    // Binary edge map.
    always_comb begin
        edge_c = (mag >= THR) ? 8'hFF : 8'h00;
    end
`else
    // Magnitude clipped to the 8-bit output range.
    always_comb begin
        edge_c = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end
`endif

    // Stage 3 register: border windows are forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_o <= '0;
            last3  <= 1'b0;
        end else if (vld_pipe[2]) begin
            edge_o <= border2 ? 8'h00 : edge_c;
            last3  <= last2;
        end
    end

    assign done_o       = vld_pipe[STAGES];
    assign frame_done_o = vld_pipe[STAGES] & last3;

endmodule
